// File: rtl/test_sequencer_pkg.sv
// Shared types and constants for the run-level test sequencer.
package test_sequencer_pkg;

    // Default calibration timeout, in cycles
    localparam int unsigned MAX_LAT_DEFAULT = 255;

    // Operand value the driver forces during the marker cycle; marker + marker is the expected DUT result
    localparam int unsigned MARKER_OPERAND = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_MARK    = 3'd2,
        ST_MEASURE = 3'd3,
        ST_RUN     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/test_sequencer_latency_probe.sv
// Latency calibration: waits for a nonzero result, then times the zero marker through the DUT.
module test_sequencer_latency_probe
    import test_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LAT_W   = 8,
    parameter int unsigned MAX_LAT = MAX_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  state_e           state_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] dut_out_i,
    output logic             prime_hit_c_o,
    output logic             valid_c_o,
    output logic             timeout_c_o,
    output logic [LAT_W-1:0] latency_o
);

    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [LAT_W-1:0] latency_q, latency_d;
    logic             zero_c;

    assign zero_c    = (dut_out_i == WIDTH'(MARKER_OPERAND));
    assign latency_o = latency_q;

    // Cycle counting and marker detection for PRIME, MARK and MEASURE
    always_comb begin
        lat_cnt_d     = lat_cnt_q;
        latency_d     = latency_q;
        prime_hit_c_o = 1'b0;
        valid_c_o     = 1'b0;
        timeout_c_o   = 1'b0;
        if (clear_i) begin
            lat_cnt_d = '0;
            latency_d = '0;
        end else begin
            case (state_i)
                ST_PRIME: begin
                    if (!zero_c)                     prime_hit_c_o = 1'b1;
                    else if (lat_cnt_q >= LAT_LIMIT) timeout_c_o   = 1'b1;
                    else                             lat_cnt_d     = lat_cnt_q + 1'b1;
                end
                ST_MARK: begin
                    if (zero_c) begin
                        valid_c_o = 1'b1;
                        latency_d = '0;
                    end else begin
                        lat_cnt_d = LAT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (zero_c) begin
                        valid_c_o = 1'b1;
                        latency_d = lat_cnt_q;
                    end else if (lat_cnt_q >= LAT_LIMIT) begin
                        timeout_c_o = 1'b1;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter and measured-latency registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_q <= '0;
            latency_q <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            latency_q <= latency_d;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Run-level controller: calibrates DUT latency, issues N vectors and gates/counts monitor checks.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned LAT_W   = 8,
    parameter int unsigned MAX_LAT = MAX_LAT_DEFAULT
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_vectors,
    input  logic [WIDTH-1:0] i_dut_out,
    input  logic             i_check_pass,
    output logic             o_lfsr_en,
    output logic             o_lfsr_load,
    output logic             o_marker,
    output logic             o_check_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [LAT_W-1:0] o_latency,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_vec_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] issue_q, issue_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [LAT_W-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;

    logic             start_ok_c, in_run_c, check_en_c, last_chk_c, lfsr_load_c;
    logic             prime_hit_c, cal_valid_c, cal_timeout_c;
    logic [LAT_W-1:0] latency;

    test_sequencer_latency_probe #(
        .WIDTH   (WIDTH),
        .LAT_W   (LAT_W),
        .MAX_LAT (MAX_LAT)
    ) u_probe (
        .clk           (clk_dut),
        .rst           (reset),
        .state_i       (state_q),
        .clear_i       (start_ok_c),
        .dut_out_i     (i_dut_out),
        .prime_hit_c_o (prime_hit_c),
        .valid_c_o     (cal_valid_c),
        .timeout_c_o   (cal_timeout_c),
        .latency_o     (latency)
    );

    // Check window opens once L run cycles have elapsed and closes after N checks
    assign start_ok_c = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_run_c   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign check_en_c = in_run_c && (wait_q == latency) && (vec_q < num_q);
    assign last_chk_c = check_en_c && (CNT_W'(vec_q + 1'b1) == num_q);

    // Next-state, counters and the Mealy reseed pulse
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        issue_d     = issue_q;
        vec_d       = vec_q;
        err_d       = err_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        lfsr_load_c = 1'b0;

        if (check_en_c) begin
            vec_d = vec_q + 1'b1;
            if (!i_check_pass && (err_q != '1)) err_d = err_q + 1'b1;
        end
        if (in_run_c && (wait_q != latency)) wait_d = wait_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_c) begin
                    state_d   = ST_PRIME;
                    num_d     = i_num_vectors;
                    vec_d     = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_PRIME: begin
                if (cal_timeout_c) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else if (prime_hit_c) begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK, ST_MEASURE: begin
                if (cal_timeout_c) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else if (cal_valid_c) begin
                    if (num_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_RUN;
                        lfsr_load_c = 1'b1;
                        issue_d     = '0;
                        wait_d      = '0;
                    end
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_RUN: begin
                issue_d = issue_q + 1'b1;
                if (issue_q == CNT_W'(num_q - 1'b1)) state_d = last_chk_c ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_chk_c) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and run registers
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            issue_q   <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            issue_q   <= issue_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_lfsr_en   = o_busy;
    assign o_lfsr_load = lfsr_load_c;
    assign o_marker    = (state_q == ST_MARK);
    assign o_check_en  = check_en_c;
    assign o_done      = (state_q == ST_DONE);
    assign o_timeout   = timeout_q;
    assign o_latency   = latency;
    assign o_err_count = err_q;
    assign o_vec_count = vec_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench: LFSR operand sources, a variable-latency adder model and a scoreboard monitor around test_sequencer.
module tb_test_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned LAT_W   = 8;
    localparam int unsigned MAX_LAT = 8;
    localparam logic [31:0] SEED_A  = 32'h0000_0001;
    localparam logic [31:0] SEED_B  = 32'hACE1_2357;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic [WIDTH-1:0] dut_out;
    logic             check_pass;
    logic             o_lfsr_en, o_lfsr_load, o_marker, o_check_en, o_busy, o_done, o_timeout;
    logic [LAT_W-1:0] o_latency;
    logic [CNT_W-1:0] o_err_count, o_vec_count;

    int n_vec = 0;
    int n_miss = 0;

    // Environment knobs set by the tests
    int          lat = 3;
    int          mode = 0;        // 0: adder model, 1: stuck all-ones, 2: stuck zero
    int          run_n = 0;
    logic [31:0] fail_mask = '0;  // bit k forces check number k (1-based) to fail

    logic [31:0] lfsr_a = SEED_A;
    logic [31:0] lfsr_b = SEED_B;
    logic [31:0] opa, opb, sum, exp_now, mask_sh;
    logic [31:0] pipe [0:15];
    logic [31:0] exp_q [$];

    int issue_left = 0, run_idx = 0, busy_cyc = 0, chk_cyc = 0, first_chk = -1;
    int load_cnt = 0, marker_cnt = 0, drain_cyc = 0, orphan_cnt = 0;
    bit run_on = 1'b0;

    test_sequencer #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .LAT_W   (LAT_W),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk_dut       (clk),
        .reset         (reset),
        .i_start       (start),
        .i_num_vectors (num),
        .i_dut_out     (dut_out),
        .i_check_pass  (check_pass),
        .o_lfsr_en     (o_lfsr_en),
        .o_lfsr_load   (o_lfsr_load),
        .o_marker      (o_marker),
        .o_check_en    (o_check_en),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .o_latency     (o_latency),
        .o_err_count   (o_err_count),
        .o_vec_count   (o_vec_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) pipe[i] = '0;
    end

    // Driver operands, DUT result model and monitor compare
    always_comb begin
        opa = o_marker ? 32'h0 : lfsr_a;
        opb = o_marker ? 32'h0 : lfsr_b;
        sum = opa + opb;
        if (mode == 1)      dut_out = '1;
        else if (mode == 2) dut_out = '0;
        else if (lat == 0)  dut_out = sum;
        else                dut_out = pipe[4'(lat - 1)];
        exp_now    = (exp_q.size() > 0) ? exp_q[0] : sum;
        mask_sh    = fail_mask >> (chk_cyc + 1);
        check_pass = (exp_now == dut_out) && !mask_sh[0];
    end

    // Operand LFSRs and the adder pipeline
    always @(posedge clk) begin
        if (o_lfsr_load) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
        end else if (o_lfsr_en) begin
            lfsr_a <= lfsr_next(lfsr_a);
            lfsr_b <= lfsr_next(lfsr_b);
        end
        pipe[0] <= sum;
        for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end

    // Scoreboard: push expected sums on issue, pop on each check; gather run statistics
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            issue_left <= 0;
            run_on     <= 1'b0;
        end else if (start && !o_busy) begin
            exp_q.delete();
            issue_left <= 0;
            run_on     <= 1'b0;
            run_idx    <= 0;
            busy_cyc   <= 0;
            chk_cyc    <= 0;
            first_chk  <= -1;
            load_cnt   <= 0;
            marker_cnt <= 0;
            drain_cyc  <= 0;
            orphan_cnt <= 0;
        end else begin
            if (o_busy)   busy_cyc   <= busy_cyc + 1;
            if (o_marker) marker_cnt <= marker_cnt + 1;
            if (o_lfsr_load) begin
                load_cnt   <= load_cnt + 1;
                issue_left <= run_n;
                run_on     <= 1'b1;
                run_idx    <= 0;
            end
            if (run_on) begin
                run_idx <= run_idx + 1;
                if (issue_left > 0) begin
                    exp_q.push_back(sum);
                    issue_left <= issue_left - 1;
                end else if (o_busy) begin
                    drain_cyc <= drain_cyc + 1;
                end
            end
            if (o_check_en) begin
                if (chk_cyc == 0) first_chk <= run_idx;
                chk_cyc <= chk_cyc + 1;
                if (exp_q.size() == 0) orphan_cnt <= orphan_cnt + 1;
                else void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_run(input int l, input int n, input int m, input logic [31:0] mask);
        bit seen;
        lat = l; mode = m; fail_mask = mask; run_n = n;
        @(negedge clk); start = 1'b1; num = CNT_W'(n);
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (o_done) seen = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("FAIL run_done l=%0d n=%0d got no o_done want o_done within 300 cycles", l, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({o_lfsr_en, o_lfsr_load, o_marker, o_check_en, o_busy, o_done, o_timeout} !== 7'b0) begin
            n_miss++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {o_lfsr_en, o_lfsr_load, o_marker, o_check_en, o_busy, o_done, o_timeout});
        end
        n_vec++;
        if ({o_latency, o_err_count, o_vec_count} !== '0) begin
            n_miss++;
            $display("FAIL reset_counts got lat=%0d err=%0d vec=%0d want 0", o_latency, o_err_count, o_vec_count);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_miss++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_pipelined();
        do_run(3, 10, 0, '0);
        n_vec++; if (o_latency !== 8'd3) begin n_miss++; $display("FAIL pipe_latency got %0d want 3", o_latency); end
        n_vec++; if (chk_cyc != 10) begin n_miss++; $display("FAIL pipe_check_cycles got %0d want 10", chk_cyc); end
        n_vec++; if (first_chk != 3) begin n_miss++; $display("FAIL pipe_first_check got %0d want 3", first_chk); end
        n_vec++; if (o_vec_count !== 32'd10) begin n_miss++; $display("FAIL pipe_vec_count got %0d want 10", o_vec_count); end
        n_vec++; if (o_err_count !== 32'd0) begin n_miss++; $display("FAIL pipe_err_count got %0d want 0", o_err_count); end
        n_vec++; if ({o_done, o_timeout} !== 2'b10) begin n_miss++; $display("FAIL pipe_done_timeout got %b want 10", {o_done, o_timeout}); end
        n_vec++; if (load_cnt != 1 || marker_cnt != 1) begin n_miss++; $display("FAIL pipe_load_marker got %0d/%0d want 1/1", load_cnt, marker_cnt); end
        n_vec++; if (drain_cyc != 3) begin n_miss++; $display("FAIL pipe_drain_cycles got %0d want 3", drain_cyc); end
        n_vec++; if (orphan_cnt != 0) begin n_miss++; $display("FAIL pipe_orphan_checks got %0d want 0", orphan_cnt); end
    endtask

    task automatic test_errors();
        do_run(3, 10, 0, (32'h1 << 2) | (32'h1 << 7));
        n_vec++; if (o_err_count !== 32'd2) begin n_miss++; $display("FAIL err_count got %0d want 2", o_err_count); end
        n_vec++; if (o_vec_count !== 32'd10) begin n_miss++; $display("FAIL err_vec_count got %0d want 10", o_vec_count); end
    endtask

    task automatic test_comb();
        do_run(0, 4, 0, '0);
        n_vec++; if (o_latency !== 8'd0) begin n_miss++; $display("FAIL comb_latency got %0d want 0", o_latency); end
        n_vec++; if (chk_cyc != 4 || first_chk != 0) begin n_miss++; $display("FAIL comb_window got %0d@%0d want 4@0", chk_cyc, first_chk); end
        n_vec++; if (drain_cyc != 0) begin n_miss++; $display("FAIL comb_drain got %0d want 0", drain_cyc); end
        n_vec++; if (o_vec_count !== 32'd4 || o_err_count !== 32'd0) begin n_miss++; $display("FAIL comb_counts got vec=%0d err=%0d want 4 0", o_vec_count, o_err_count); end
    endtask

    task automatic test_timeout();
        do_run(3, 5, 1, '0);
        n_vec++; if ({o_done, o_timeout} !== 2'b11) begin n_miss++; $display("FAIL meas_to_flags got %b want 11", {o_done, o_timeout}); end
        n_vec++; if (o_vec_count !== 32'd0 || chk_cyc != 0) begin n_miss++; $display("FAIL meas_to_vec got %0d/%0d want 0/0", o_vec_count, chk_cyc); end
        n_vec++; if (busy_cyc != 10) begin n_miss++; $display("FAIL meas_to_cycles got %0d want 10", busy_cyc); end
        do_run(3, 5, 2, '0);
        n_vec++; if ({o_done, o_timeout} !== 2'b11) begin n_miss++; $display("FAIL prime_to_flags got %b want 11", {o_done, o_timeout}); end
        n_vec++; if (o_vec_count !== 32'd0) begin n_miss++; $display("FAIL prime_to_vec got %0d want 0", o_vec_count); end
        n_vec++; if (busy_cyc != 9) begin n_miss++; $display("FAIL prime_to_cycles got %0d want 9", busy_cyc); end
    endtask

    task automatic test_zero_n();
        do_run(2, 0, 0, '0);
        n_vec++; if (o_latency !== 8'd2) begin n_miss++; $display("FAIL zero_n_latency got %0d want 2", o_latency); end
        n_vec++; if (o_vec_count !== 32'd0 || o_err_count !== 32'd0) begin n_miss++; $display("FAIL zero_n_counts got vec=%0d err=%0d want 0 0", o_vec_count, o_err_count); end
        n_vec++; if (chk_cyc != 0 || load_cnt != 0) begin n_miss++; $display("FAIL zero_n_activity got chk=%0d load=%0d want 0 0", chk_cyc, load_cnt); end
        n_vec++; if (o_timeout !== 1'b0) begin n_miss++; $display("FAIL zero_n_timeout got %b want 0", o_timeout); end
    endtask

    task automatic test_midrun_start();
        bit seen;
        bit done_seen;
        lat = 3; mode = 0; fail_mask = '0; run_n = 10;
        @(negedge clk); start = 1'b1; num = CNT_W'(10);
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (o_lfsr_load) seen = 1'b1;
            else @(negedge clk);
        end
        n_vec++; if (!seen) begin n_miss++; $display("FAIL midrun_load got no o_lfsr_load want pulse within 50 cycles"); end
        repeat (3) @(negedge clk);
        start = 1'b1; num = CNT_W'(3);
        @(negedge clk); start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 100 && !done_seen; i++) begin
            if (o_done) done_seen = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!done_seen || o_vec_count !== 32'd10 || chk_cyc != 10) begin
            n_miss++;
            $display("FAIL midrun_start got done=%b vec=%0d chk=%0d want 1 10 10", done_seen, o_vec_count, chk_cyc);
        end
    endtask

    task automatic test_reset_drain();
        bit seen;
        lat = 3; mode = 0; fail_mask = '0; run_n = 10;
        @(negedge clk); start = 1'b1; num = CNT_W'(10);
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (run_on && issue_left == 0 && o_busy) seen = 1'b1;
            else @(negedge clk);
        end
        n_vec++; if (!seen) begin n_miss++; $display("FAIL drain_reach got no drain want drain within 100 cycles"); end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({o_lfsr_en, o_lfsr_load, o_marker, o_check_en, o_busy, o_done, o_timeout} !== 7'b0 ||
            {o_latency, o_err_count, o_vec_count} !== '0) begin
            n_miss++;
            $display("FAIL drain_reset got ctrl=%b lat=%0d err=%0d vec=%0d want all 0",
                     {o_lfsr_en, o_lfsr_load, o_marker, o_check_en, o_busy, o_done, o_timeout},
                     o_latency, o_err_count, o_vec_count);
        end
        @(negedge clk); reset = 1'b0;
        do_run(3, 5, 0, '0);
        n_vec++; if (load_cnt != 1) begin n_miss++; $display("FAIL rerun_load got %0d want 1", load_cnt); end
        n_vec++; if (o_vec_count !== 32'd5 || o_err_count !== 32'd0) begin n_miss++; $display("FAIL rerun_counts got vec=%0d err=%0d want 5 0", o_vec_count, o_err_count); end
    endtask

    initial begin
        test_reset();
        test_pipelined();
        test_errors();
        test_comb();
        test_timeout();
        test_zero_n();
        test_midrun_start();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Run-level controller for the arithmetic testbench.
- Calibrates DUT latency with a zero-operand marker, then issues a programmed number of random vectors.
- Gates monitor comparison to the cycles where DUT results are valid, and reports error and vector counts.
- Sits between the LFSR operand sources, the driver (marker/zero injection) and the monitor, all on the DUT clock.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 32, vector and error counter width
LAT_W, 8, latency counter width
MAX_LAT, 255, latency timeout limit in cycles (must be at most 2^LAT_W-1)

Ports:
clk_dut  in  1  sole clock; everything in this block is on clk_dut
reset  in  1  asynchronous, active-high reset
i_start  in  1  start pulse; accepted only in IDLE or DONE
i_num_vectors  in  CNT_W  vectors to issue; sampled on accepted start
i_dut_out  in  WIDTH  DUT result
i_check_pass  in  1  monitor compare result for current cycle; used only when o_check_en=1
o_lfsr_en  out  1  advance operand LFSRs
o_lfsr_load  out  1  reseed operand LFSRs (one cycle)
o_marker  out  1  driver forces both operands to 0
o_check_en  out  1  monitor result is valid this cycle
o_busy  out  1  run in progress
o_done  out  1  run finished; held until next accepted start
o_timeout  out  1  calibration failed; valid with o_done
o_latency  out  LAT_W  measured DUT latency
o_err_count  out  CNT_W  failed checks, saturating
o_vec_count  out  CNT_W  completed checks

Behaviour:
- Reset: state IDLE. All outputs 0. Counters and latency cleared. Reset mid-run aborts immediately; no partial results are retained.
- States: IDLE, PRIME, MARK, MEASURE, RUN, DRAIN, DONE.
- Control outputs decode from the registered state (Moore), except o_lfsr_load (Mealy, see MEASURE).
- o_busy=1 in PRIME through DRAIN.
- o_lfsr_en=1 in PRIME, MARK, MEASURE, RUN, DRAIN.
- IDLE/DONE: on i_start, go to PRIME.
  - Latch i_num_vectors.
  - Clear o_err_count, o_vec_count, o_latency, o_timeout, o_done.
- i_start in any other state is ignored.
- PRIME: drive random operands until i_dut_out != 0, then go to MARK. If MAX_LAT+1 cycles pass without a nonzero output, go to DONE with o_timeout=1.
- MARK (one cycle): o_marker=1.
  - If i_dut_out==0 this cycle: latency=0 (combinational DUT), go to RUN.
  - Otherwise go to MEASURE with lat_cnt=1.
- MEASURE: o_marker=0.
  - If i_dut_out==0: o_latency<=lat_cnt, go to RUN.
  - Else lat_cnt++. If lat_cnt==MAX_LAT without a zero, go to DONE with o_timeout=1.
- o_lfsr_load=1 combinationally in the cycle that leaves MARK or MEASURE for RUN, so every run's vector stream starts from the seed.
- Latched N==0: calibration completes, then go directly to DONE; no checks are performed.
- RUN: one vector per cycle for N cycles; issue counter k runs 0..N-1. Then go to DRAIN.
- Check window: o_check_en=1 in RUN or DRAIN when run-cycle index (from first RUN cycle) >= L and o_vec_count < N. This gives exactly N check cycles, the first at index L.
- On each check cycle:
  - o_vec_count++.
  - If !i_check_pass, o_err_count++, saturating at all-ones.
- DRAIN: continue until o_vec_count==N, then go to DONE.
- DONE: o_done=1. o_latency and the counters hold.
- Simultaneous: the last check and the DRAIN→DONE transition occur in the same cycle; that check's pass/fail is counted.

Decomposition:
- Shared package holds:
  - the state enum (3-bit, encoding listed above);
  - the MAX_LAT default;
  - the marker operand constant (all zeros).
- One sub-module: latency_probe. It owns PRIME/MARK/MEASURE and the lat_cnt, and outputs latency, valid, timeout.
- The top FSM owns RUN/DRAIN/DONE and the counters.

Test Plan:
- 3-stage pipelined adder, N=10, i_check_pass=1 → o_latency=3; o_check_en high exactly 10 cycles starting at RUN index 3; o_vec_count=10; o_err_count=0; o_done=1, o_timeout=0.
- Same setup, i_check_pass forced 0 on checks 2 and 7 → o_err_count=2, o_vec_count=10.
- Combinational adder (L=0), N=4 → o_latency=0; o_check_en high in the first 4 RUN cycles; DRAIN lasts 0 cycles.
- i_dut_out stuck at 0xFFFF_FFFF, MAX_LAT=8 → MEASURE times out; o_done=1, o_timeout=1, o_vec_count=0. Output stuck at 0 → PRIME timeout with the same result.
- N=0 with L=2 → DONE reached after calibration; o_latency=2, counters 0, o_check_en never high.
- i_start pulsed mid-RUN → ignored. Reset asserted in DRAIN → all outputs 0 immediately. A new start then runs cleanly with o_lfsr_load pulsed once.
